axi_fifo_drain: RTL

- Reader end of the interconnect's push/pop FIFO. Pops entries from a FIFO whose read data is combinational at the read pointer (`i_fifo_data` valid whenever `i_fifo_empty` is low).
- Presents the entries as an AXI-style VALID/READY channel source.
- Uses a 2-entry output buffer (head plus skid), so the pop path never depends combinationally on `i_ready`, while still sustaining one beat per cycle.
- Sits between each channel FIFO and the AXI port driver.

---
 rtl/axi_fifo_drain_if.sv | 25 ++
 rtl/axi_fifo_drain.sv | 98 +++++++++
 2 files changed

// File: rtl/axi_fifo_drain_if.sv
// Bus bundle for axi_fifo_drain: FIFO read side plus the VALID/READY source channel.
// master = the drain block, slave = the FIFO / AXI port driver side.
interface axi_fifo_drain_if #(
  parameter int DW = 8,
  parameter int LW = 8
);
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_fifo_pop;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          i_ready;
  logic [LW-1:0] i_burst_len;

  modport master (
    input  i_fifo_data, i_fifo_empty, i_ready, i_burst_len,
    output o_fifo_pop, o_valid, o_data, o_last
  );

  modport slave (
    output i_fifo_data, i_fifo_empty, i_ready, i_burst_len,
    input  o_fifo_pop, o_valid, o_data, o_last
  );
endinterface

// File: rtl/axi_fifo_drain.sv
// Reader end of a push/pop FIFO, presented as a VALID/READY source.
// Two-entry output buffer (head + skid): the pop decision only looks at the
// registered occupancy and the FIFO empty flag, never at i_ready, yet a
// steady stream still moves one beat per cycle.
// Optional macro AXI_FIFO_DRAIN_LAST_GEN_EN: generate o_last from a beat
// counter against i_burst_len; otherwise every beat is last.
module axi_fifo_drain #(
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  axi_fifo_drain_if.master  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] head;
  logic [DW-1:0] skid;
  logic          pop;
  logic          hs;

  // Pop whenever there is room; reset gates it so nothing is consumed then.
  assign pop            = i_resetn & ~bus.i_fifo_empty & (state != TWO);
  assign hs             = bus.o_valid & bus.i_ready;
  assign bus.o_fifo_pop = pop;
  assign bus.o_valid    = (state != EMPTY);
  assign bus.o_data     = head;

  // Occupancy FSM and data moves; skid is always older than any new pop.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (pop) begin
            head  <= bus.i_fifo_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (pop && hs) begin
            head <= bus.i_fifo_data;
          end else if (pop) begin
            skid  <= bus.i_fifo_data;
            state <= TWO;
          end else if (hs) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (hs) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef AXI_FIFO_DRAIN_LAST_GEN_EN
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] eff_len;
  logic          at_last;

  // First beat follows the live length; later beats use the copy taken then.
  assign eff_len    = (cnt == '0) ? bus.i_burst_len : len_q;
  assign at_last    = (cnt == eff_len);
  assign bus.o_last = bus.o_valid & at_last;

  // Beat counter: advance on each handshake, wrap after the last beat.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      cnt   <= '0;
      len_q <= '0;
    end else if (hs) begin
      if (cnt == '0) len_q <= bus.i_burst_len;
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end
`else
  logic [LW-1:0] unused_burst_len;

  assign unused_burst_len = bus.i_burst_len;
  assign bus.o_last       = 1'b1;
`endif

endmodule
